spi_adc_responder: RTL

Synthesizable SPI responder that emulates an 8-channel, 12-bit MCP3208-style ADC. It answers the frames issued by the existing SPI ADC controller, so the controller can be exercised without the physical converter: on the bench, in on-board loop-back, or when a second board supplies sensor values over SPI. Channel samples come from parallel inputs. The protocol is pipelined: each 16-bit frame returns the channel addressed in the previous frame.

---
 rtl/spi_adc_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating an 8-channel 12-bit MCP3208-style ADC.
// Each frame returns the channel addressed in the previous frame.
module spi_adc_responder #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_sck,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  input  logic [12*NUM_CH-1:0]   ch_data,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [2:0]             frame_addr,
  output logic [2:0]             next_addr
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;

  state_e      state_q;
  logic [15:0] tx_q;
  logic [2:0]  rx_q;
  logic [4:0]  rise_q;
  logic        miso_q;
  logic        oe_q;
  logic        done_q;
  logic        err_q;
  logic [2:0]  faddr_q;
  logic [2:0]  naddr_q;

  logic        sck_s;
  logic        cs_s;
  logic        mosi_s;
  logic        sck_rise;
  logic        sck_fall;
  logic        cs_rise;
  logic        cs_fall;
  logic [11:0] sample;

  // cs_n chain resets low so a frame left open across reset is not restarted
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_comb begin
    sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (naddr_q == 3'(c)) begin
        sample = ch_data[12*c +: 12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rise_q  <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      faddr_q <= '0;
      naddr_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          oe_q   <= 1'b0;
          if (cs_fall) begin
            tx_q    <= {4'b0000, sample};
            miso_q  <= 1'b0;
            oe_q    <= 1'b1;
            rise_q  <= '0;
            rx_q    <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            err_q   <= 1'b1;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end else if (sck_rise) begin
            rise_q <= rise_q + 5'd1;
            if (rise_q >= 5'd2 && rise_q <= 5'd4) begin
              rx_q <= {rx_q[1:0], mosi_s};
            end
            if (rise_q == 5'd15) begin
              miso_q  <= 1'b0;
              state_q <= DONE;
            end
          end else if (sck_fall && rise_q != 5'd0) begin
            tx_q   <= {tx_q[14:0], 1'b0};
            miso_q <= tx_q[14];
          end
        end
        DONE: begin
          miso_q <= 1'b0;
          if (cs_rise) begin
            faddr_q <= naddr_q;
            naddr_q <= rx_q;
            done_q  <= 1'b1;
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign frame_addr  = faddr_q;
  assign next_addr   = naddr_q;

endmodule
